// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg : shared state/owner encodings for the unified memory arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_BUSY = ARB_BUSY,
        ST_RESP = ARB_RESP
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_grant_logic.sv
// ============================================================================
// arb_grant_logic : data-priority grant select with fetch anti-starvation streak
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_grant_logic
    import arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_fetch_req,
    input  logic i_data_req,
    input  logic i_grant_stb,
    output logic o_grant_valid,
    output logic o_grant_owner
);

    localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_streak;
    logic       w_owner;

    // Data wins unless a fetch has already waited through STARVE_LIMIT data grants.
    assign w_owner       = (i_data_req && (!i_fetch_req || (r_streak < c_limit))) ? OWNER_D : OWNER_I;
    assign o_grant_valid = i_fetch_req | i_data_req;
    assign o_grant_owner = w_owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak <= 4'd0;
        end else if (i_grant_stb) begin
            if ((w_owner == OWNER_D) && i_fetch_req) begin
                r_streak <= (r_streak == c_limit) ? c_limit : r_streak + 4'd1;
            end else begin
                r_streak <= 4'd0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// unified_mem_arbiter : shares one multi-cycle memory port between fetch and data
// Revision: 1.0
// ============================================================================
`default_nettype none

module unified_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_we;
    logic              r_mem_req;
    logic              r_i_ready;
    logic              r_d_ready;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_grant_valid;
    logic w_grant_owner;
    logic w_grant_stb;

    assign w_grant_stb = (r_state == ST_IDLE) && w_grant_valid;

    arb_grant_logic #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk           (clk),
        .reset         (reset),
        .i_fetch_req   (i_req),
        .i_data_req    (d_req),
        .i_grant_stb   (w_grant_stb),
        .o_grant_valid (w_grant_valid),
        .o_grant_owner (w_grant_owner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWNER_I;
            r_we      <= 1'b0;
            r_mem_req <= 1'b0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner   <= w_grant_owner;
                        r_mem_req <= 1'b1;
                        r_state   <= ST_BUSY;
                        if (w_grant_owner == OWNER_D) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                        end else begin
                            r_addr  <= i_addr;
                            r_we    <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        // Stores leave the data read register untouched.
                        if (!r_we) begin
                            if (r_owner == OWNER_D) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                        r_mem_req <= 1'b0;
                        r_we      <= 1'b0;
                        r_i_ready <= (r_owner == OWNER_I);
                        r_d_ready <= (r_owner == OWNER_D);
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i_rdata   = r_i_rdata;
    assign i_ready   = r_i_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

`default_nettype wire
